// File: rtl/ppu_sprite_pkg.sv
// Shared types and bit-field positions for the sprite pixel pipeline.
package ppu_sprite_pkg;

  typedef enum logic [1:0] {IDLE, WAIT, SHIFT, DONE} slot_state_t;

  // OAM attribute byte fields
  localparam int unsigned ATTR_FLIP   = 6;
  localparam int unsigned ATTR_PRIO   = 5;
  localparam int unsigned ATTR_PAL_LO = 0;

  // Sprite pixel fields {s0, prio, pal[1:0], pat[1:0]}
  localparam int unsigned PIX_S0     = 5;
  localparam int unsigned PIX_PRIO   = 4;
  localparam int unsigned PIX_PAL_LO = 2;
  localparam int unsigned PIX_PAT_LO = 0;

  function automatic logic [7:0] bitrev8(input logic [7:0] v);
    logic [7:0] r;
    r = '0;
    for (int unsigned i = 0; i < 8; i++) r[i] = v[7-i];
    return r;
  endfunction

endpackage

// File: rtl/sprite_slot.sv
// One sprite slot: X countdown, then 8 pixels shifted out MSB-first per render dot.
module sprite_slot
  import ppu_sprite_pkg::*;
#(
  parameter int unsigned X_WIDTH  = 8,
  parameter bit          IS_SLOT0 = 1'b0
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               en_i,
  input  logic               render_i,
  input  logic               load_i,
  input  logic               clear_i,
  input  logic [7:0]         pat_lo_i,
  input  logic [7:0]         pat_hi_i,
  input  logic [7:0]         attr_i,
  input  logic [X_WIDTH-1:0] x_i,
  input  logic               s0_i,
  output logic               active_o,
  output logic [3:0]         nibble_o,
  output logic               prio_o,
  output logic               s0_o
);

  slot_state_t        state_q;
  logic [X_WIDTH-1:0] x_q;
  logic [2:0]         shift_q;
  logic [7:0]         lo_q, hi_q;
  logic [1:0]         pal_q;
  logic               prio_q, s0_q;
  logic               shifting;
  logic               unused_attr;

  assign unused_attr = ^{attr_i[7], attr_i[4:2]};

  // The dot on which the X countdown reaches zero already emits pixel 0.
  assign shifting = (state_q == SHIFT) || (state_q == WAIT && x_q == '0);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      x_q     <= '0;
      shift_q <= '0;
      lo_q    <= '0;
      hi_q    <= '0;
      pal_q   <= '0;
      prio_q  <= 1'b0;
      s0_q    <= 1'b0;
    end else if (en_i) begin
      if (load_i) begin
        lo_q    <= attr_i[ATTR_FLIP] ? bitrev8(pat_lo_i) : pat_lo_i;
        hi_q    <= attr_i[ATTR_FLIP] ? bitrev8(pat_hi_i) : pat_hi_i;
        pal_q   <= attr_i[ATTR_PAL_LO +: 2];
        prio_q  <= attr_i[ATTR_PRIO];
        s0_q    <= IS_SLOT0 && s0_i;
        x_q     <= x_i;
        shift_q <= '0;
        state_q <= WAIT;
      end else if (clear_i) begin
        lo_q    <= '0;
        hi_q    <= '0;
        state_q <= DONE;
      end else if (render_i) begin
        case (state_q)
          WAIT: begin
            if (x_q == '0) begin
              lo_q    <= {lo_q[6:0], 1'b0};
              hi_q    <= {hi_q[6:0], 1'b0};
              shift_q <= 3'd7;
              state_q <= SHIFT;
            end else begin
              x_q <= x_q - X_WIDTH'(1);
            end
          end
          SHIFT: begin
            lo_q    <= {lo_q[6:0], 1'b0};
            hi_q    <= {hi_q[6:0], 1'b0};
            shift_q <= shift_q - 3'd1;
            if (shift_q == 3'd1) state_q <= DONE;
          end
          default: ;
        endcase
      end
    end
  end

  assign active_o = shifting && !load_i;
  assign nibble_o = {pal_q, hi_q[7], lo_q[7]};
  assign prio_o   = prio_q;
  assign s0_o     = s0_q;

endmodule

// File: rtl/sprite_pixel_scheduler.sv
// Per-scanline sprite output: slot array, dot counter, priority encoder, output register.
module sprite_pixel_scheduler
  import ppu_sprite_pkg::*;
#(
  parameter int unsigned SLOT_COUNT = 8,
  parameter int unsigned X_WIDTH    = 8
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          clock_EN,
  input  logic                          lineStart,
  input  logic                          render_EN,
  input  logic                          showLeft8,
  input  logic                          clearSlots,
  input  logic                          load_EN,
  input  logic [$clog2(SLOT_COUNT)-1:0] load_slot,
  input  logic [7:0]                    load_patternLow,
  input  logic [7:0]                    load_patternHigh,
  input  logic [7:0]                    load_attribute,
  input  logic [X_WIDTH-1:0]            load_x,
  input  logic                          load_isSprite0,
  output logic [5:0]                    spritePixel,
  output logic [SLOT_COUNT-1:0]         slotActiveMask
);

  localparam int unsigned SW = $clog2(SLOT_COUNT);
  localparam logic [X_WIDTH-1:0] DOT_MAX = '1;

  logic [X_WIDTH-1:0]    dot_q, dot_d, dot_cur;
  logic [SLOT_COUNT-1:0] active, prio, s0;
  logic [3:0]            nibble [SLOT_COUNT];
  logic [5:0]            pix_d;
  logic [SLOT_COUNT-1:0] mask_d;
  logic                  found;

  for (genvar g = 0; g < SLOT_COUNT; g++) begin : g_slot
    sprite_slot #(
      .X_WIDTH (X_WIDTH),
      .IS_SLOT0(g == 0)
    ) u_slot (
      .clk_i   (clock),
      .rst_i   (reset),
      .en_i    (clock_EN),
      .render_i(render_EN),
      .load_i  (load_EN && (load_slot == SW'(g))),
      .clear_i (clearSlots),
      .pat_lo_i(load_patternLow),
      .pat_hi_i(load_patternHigh),
      .attr_i  (load_attribute),
      .x_i     (load_x),
      .s0_i    (load_isSprite0),
      .active_o(active[g]),
      .nibble_o(nibble[g]),
      .prio_o  (prio[g]),
      .s0_o    (s0[g])
    );
  end

  // lineStart makes the current dot 0 even though dot_q has not been cleared yet.
  always_comb begin
    dot_cur = lineStart ? '0 : dot_q;
    dot_d   = dot_q;
    if (lineStart)                              dot_d = render_EN ? X_WIDTH'(1) : '0;
    else if (render_EN && dot_q != DOT_MAX)     dot_d = dot_q + X_WIDTH'(1);
  end

  always_comb begin
    pix_d  = '0;
    mask_d = '0;
    found  = 1'b0;
    if (render_EN) begin
      for (int unsigned i = 0; i < SLOT_COUNT; i++) begin
        mask_d[i] = active[i];
        if (!found && active[i] && nibble[i][1:0] != 2'b00) begin
          found                    = 1'b1;
          pix_d[PIX_S0]            = s0[i];
          pix_d[PIX_PRIO]          = prio[i];
          pix_d[PIX_PAL_LO +: 2]   = nibble[i][3:2];
          pix_d[PIX_PAT_LO +: 2]   = nibble[i][1:0];
        end
      end
      if (!showLeft8 && dot_cur < X_WIDTH'(8)) pix_d = '0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      dot_q          <= '0;
      spritePixel    <= '0;
      slotActiveMask <= '0;
    end else if (clock_EN) begin
      dot_q          <= dot_d;
      spritePixel    <= pix_d;
      slotActiveMask <= mask_d;
    end
  end

endmodule

// File: tb/tb_sprite_pixel_scheduler.sv
// Self-checking bench: directed vector table, corner sequences, randomized run vs. reference model.
module tb_sprite_pixel_scheduler;

  localparam int SC = 8;

  logic       clock = 1'b0, reset = 1'b1;
  logic       clock_EN = 1'b0, lineStart = 1'b0, render_EN = 1'b0, showLeft8 = 1'b0;
  logic       clearSlots = 1'b0, load_EN = 1'b0, load_isSprite0 = 1'b0;
  logic [2:0] load_slot = '0;
  logic [7:0] load_patternLow = '0, load_patternHigh = '0, load_attribute = '0, load_x = '0;
  logic [5:0] spritePixel;
  logic [7:0] slotActiveMask;

  sprite_pixel_scheduler #(.SLOT_COUNT(SC), .X_WIDTH(8)) dut (
    .clock           (clock),
    .reset           (reset),
    .clock_EN        (clock_EN),
    .lineStart       (lineStart),
    .render_EN       (render_EN),
    .showLeft8       (showLeft8),
    .clearSlots      (clearSlots),
    .load_EN         (load_EN),
    .load_slot       (load_slot),
    .load_patternLow (load_patternLow),
    .load_patternHigh(load_patternHigh),
    .load_attribute  (load_attribute),
    .load_x          (load_x),
    .load_isSprite0  (load_isSprite0),
    .spritePixel     (spritePixel),
    .slotActiveMask  (slotActiveMask)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  // Reference model: each slot remembers how many render dots it has seen since load.
  bit         m_valid [SC];
  int         m_n     [SC];
  int         m_x     [SC];
  logic [7:0] m_lo    [SC];
  logic [7:0] m_hi    [SC];
  logic [7:0] m_attr  [SC];
  bit         m_s0    [SC];
  int         m_dot;
  logic [5:0] exp_pix;
  logic [7:0] exp_mask;
  logic [5:0] got [300];

  typedef struct {
    string      name;
    int         slot;
    int         x;
    logic [7:0] lo;
    logic [7:0] hi;
    logic [7:0] attr;
    bit         s0;
    bit         sl8;
    int         dot;
    logic [5:0] exp;
  } vec_t;

  vec_t vt[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < SC; i++) begin
      m_valid[i] = 0; m_n[i] = 0; m_x[i] = 0;
      m_lo[i] = '0; m_hi[i] = '0; m_attr[i] = '0; m_s0[i] = 0;
    end
    m_dot    = 0;
    exp_pix  = '0;
    exp_mask = '0;
  endfunction

  function automatic void model_eval();
    int         dcur, k, b;
    bit         win, act, ld;
    logic [1:0] p;
    logic [5:0] pix;
    logic [7:0] mask;
    if (!clock_EN) return;
    dcur = lineStart ? 0 : m_dot;
    pix  = '0;
    mask = '0;
    win  = 0;
    if (render_EN) begin
      for (int i = 0; i < SC; i++) begin
        ld  = load_EN && (int'(load_slot) == i);
        act = m_valid[i] && (m_n[i] >= m_x[i]) && (m_n[i] < m_x[i] + 8) && !ld;
        if (act) begin
          mask[i] = 1'b1;
          k = m_n[i] - m_x[i];
          b = m_attr[i][6] ? k : 7 - k;
          p = {m_hi[i][b], m_lo[i][b]};
          if (p != 2'b00 && !win) begin
            win = 1;
            pix = {(i == 0) && m_s0[i], m_attr[i][5], m_attr[i][1:0], p};
          end
        end
      end
      if (dcur < 8 && !showLeft8) pix = '0;
    end
    exp_pix  = pix;
    exp_mask = mask;
    for (int i = 0; i < SC; i++) begin
      if (load_EN && int'(load_slot) == i) begin
        m_valid[i] = 1; m_n[i] = 0; m_x[i] = int'(load_x);
        m_lo[i] = load_patternLow; m_hi[i] = load_patternHigh;
        m_attr[i] = load_attribute; m_s0[i] = load_isSprite0;
      end else if (clearSlots) begin
        m_valid[i] = 0;
      end else if (render_EN && m_valid[i] && m_n[i] < 1000) begin
        m_n[i]++;
      end
    end
    if (lineStart)                   m_dot = render_EN ? 1 : 0;
    else if (render_EN && m_dot < 255) m_dot++;
  endfunction

  task automatic tick();
    model_eval();
    @(posedge clock);
    #1;
    chk("pixel", 32'(spritePixel), 32'(exp_pix));
    chk("mask", 32'(slotActiveMask), 32'(exp_mask));
  endtask

  task automatic set_idle();
    clock_EN = 1'b1; render_EN = 1'b0; lineStart = 1'b0;
    load_EN = 1'b0; clearSlots = 1'b0;
  endtask

  task automatic do_load(input int slot, input int x, input logic [7:0] lo, input logic [7:0] hi,
                         input logic [7:0] attr, input bit s0);
    set_idle();
    load_EN = 1'b1; load_slot = 3'(slot); load_x = 8'(x);
    load_patternLow = lo; load_patternHigh = hi; load_attribute = attr; load_isSprite0 = s0;
    tick();
    load_EN = 1'b0;
  endtask

  task automatic do_clear();
    set_idle();
    clearSlots = 1'b1;
    tick();
    clearSlots = 1'b0;
  endtask

  task automatic run_line(input bit sl8, input int n);
    for (int d = 0; d < n; d++) begin
      set_idle();
      render_EN = 1'b1; lineStart = (d == 0); showLeft8 = sl8;
      tick();
      got[d] = spritePixel;
    end
    set_idle();
    tick();
  endtask

  initial begin
    model_reset();
    repeat (2) @(posedge clock);
    #1;
    chk("reset_pixel", 32'(spritePixel), 32'h0);
    chk("reset_mask", 32'(slotActiveMask), 32'h0);
    @(negedge clock);
    reset = 1'b0;

    vt.push_back('{"single_d10", 3, 10,  8'hF0, 8'h00, 8'h02, 0, 1, 10,  6'b001001});
    vt.push_back('{"single_d13", 3, 10,  8'hF0, 8'h00, 8'h02, 0, 1, 13,  6'b001001});
    vt.push_back('{"single_d14", 3, 10,  8'hF0, 8'h00, 8'h02, 0, 1, 14,  6'b000000});
    vt.push_back('{"single_d9",  3, 10,  8'hF0, 8'h00, 8'h02, 0, 1, 9,   6'b000000});
    vt.push_back('{"flip_d10",   3, 10,  8'hF0, 8'h00, 8'h42, 0, 1, 10,  6'b000000});
    vt.push_back('{"flip_d14",   3, 10,  8'hF0, 8'h00, 8'h42, 0, 1, 14,  6'b001001});
    vt.push_back('{"flip_d17",   3, 10,  8'hF0, 8'h00, 8'h42, 0, 1, 17,  6'b001001});
    vt.push_back('{"s0_slot0",   0, 5,   8'hFF, 8'h00, 8'h20, 1, 1, 5,   6'b110001});
    vt.push_back('{"s0_slot2",   2, 5,   8'hFF, 8'h00, 8'h20, 1, 1, 5,   6'b010001});
    vt.push_back('{"clip_d4",    1, 4,   8'hFF, 8'h00, 8'h00, 0, 0, 4,   6'b000000});
    vt.push_back('{"clip_d7",    1, 4,   8'hFF, 8'h00, 8'h00, 0, 0, 7,   6'b000000});
    vt.push_back('{"clip_d8",    1, 4,   8'hFF, 8'h00, 8'h00, 0, 0, 8,   6'b000001});
    vt.push_back('{"clip_d11",   1, 4,   8'hFF, 8'h00, 8'h00, 0, 0, 11,  6'b000001});
    vt.push_back('{"noclip_d4",  1, 4,   8'hFF, 8'h00, 8'h00, 0, 1, 4,   6'b000001});
    vt.push_back('{"x0_d0",      0, 0,   8'h80, 8'h00, 8'h00, 0, 1, 0,   6'b000001});
    vt.push_back('{"x0_d1",      0, 0,   8'h80, 8'h00, 8'h00, 0, 1, 1,   6'b000000});
    vt.push_back('{"hi_plane",   5, 3,   8'h00, 8'h80, 8'h01, 0, 1, 3,   6'b000110});
    vt.push_back('{"dot_sat",    4, 255, 8'hFF, 8'h00, 8'h00, 0, 0, 258, 6'b000001});

    foreach (vt[i]) begin
      do_clear();
      do_load(vt[i].slot, vt[i].x, vt[i].lo, vt[i].hi, vt[i].attr, vt[i].s0);
      run_line(vt[i].sl8, 300);
      chk(vt[i].name, 32'(got[vt[i].dot]), 32'(vt[i].exp));
    end

    // Overlapping slots: transparent pixels of slot 0 do not hide slot 1.
    do_clear();
    do_load(0, 20, 8'h0F, 8'h00, 8'h00, 0);
    do_load(1, 20, 8'hFF, 8'h00, 8'h03, 0);
    run_line(1, 40);
    chk("ovl_d20", 32'(got[20]), 32'(6'b001101));
    chk("ovl_d23", 32'(got[23]), 32'(6'b001101));
    chk("ovl_d24", 32'(got[24]), 32'(6'b000001));
    chk("ovl_d27", 32'(got[27]), 32'(6'b000001));

    // Reload of a shifting slot on a render dot: that dot is transparent, pixel 0 follows.
    do_clear();
    do_load(0, 0, 8'hFF, 8'h00, 8'h00, 0);
    for (int d = 0; d < 10; d++) begin
      set_idle();
      render_EN = 1'b1; lineStart = (d == 0); showLeft8 = 1'b1;
      if (d == 2) begin
        load_EN = 1'b1; load_slot = 3'd0; load_x = 8'd0;
        load_patternLow = 8'hFF; load_patternHigh = 8'h00; load_attribute = 8'h00;
      end
      tick();
      got[d] = spritePixel;
    end
    chk("reload_d1", 32'(got[1]), 32'(6'b000001));
    chk("reload_d2", 32'(got[2]), 32'h0);
    chk("reload_d3", 32'(got[3]), 32'(6'b000001));

    // Asynchronous reset between clock edges while a slot is shifting.
    do_clear();
    do_load(0, 0, 8'hFF, 8'h00, 8'h00, 0);
    for (int d = 0; d < 3; d++) begin
      set_idle();
      render_EN = 1'b1; lineStart = (d == 0); showLeft8 = 1'b1;
      tick();
    end
    #2 reset = 1'b1;
    #1;
    chk("async_rst_pixel", 32'(spritePixel), 32'h0);
    chk("async_rst_mask", 32'(slotActiveMask), 32'h0);
    @(negedge clock);
    reset = 1'b0;
    model_reset();
    run_line(1, 30);
    chk("post_rst_d10", 32'(got[10]), 32'h0);

    // Randomized traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      clock_EN         = ($urandom_range(0, 9) != 0);
      render_EN        = ($urandom_range(0, 9) < 8);
      lineStart        = ($urandom_range(0, 59) == 0);
      showLeft8        = 1'($urandom_range(0, 1));
      clearSlots       = ($urandom_range(0, 99) == 0);
      load_EN          = ($urandom_range(0, 7) == 0);
      load_slot        = 3'($urandom_range(0, 7));
      load_patternLow  = 8'($urandom);
      load_patternHigh = 8'($urandom);
      load_attribute   = 8'($urandom);
      load_x           = 8'($urandom_range(0, 40));
      load_isSprite0   = 1'($urandom_range(0, 1));
      tick();
    end
    set_idle();
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sprite_pixel_scheduler.md
Name: sprite_pixel_scheduler

Overview:
- Per-scanline sprite output unit. Holds up to SLOT_COUNT sprites loaded during horizontal blank.
- Counts each sprite down to its X position, then shifts out its 8 pattern bits one per dot.
- Arbitrates between overlapping slots by slot index and emits the 6-bit sprite pixel consumed by the downstream background/sprite priority mux: [5]=sprite-0 flag, [4]=behind-background, [3:2]=palette, [1:0]=pattern.

Parameters:
- SLOT_COUNT, 8, number of sprite slots; slot 0 has highest priority.
- X_WIDTH, 8, width of the dot and X counters.

Ports:
- clock  in  1  PPU clock.
- reset  in  1  asynchronous, active-high reset.
- clock_EN  in  1  dot strobe; all state advances only when high.
- lineStart  in  1  qualified by clock_EN; zeroes the dot counter for a new visible line.
- render_EN  in  1  qualified by clock_EN; this dot is a visible output dot.
- showLeft8  in  1  0 blanks sprite output for dots 0-7.
- clearSlots  in  1  qualified by clock_EN; zeroes every slot's pattern, so all slots become transparent.
- load_EN  in  1  qualified by clock_EN; writes one slot.
- load_slot  in  $clog2(SLOT_COUNT)  target slot index.
- load_patternLow  in  8  pattern plane 0, bit 7 = leftmost pixel.
- load_patternHigh  in  8  pattern plane 1.
- load_attribute  in  8  OAM byte 2: [1:0] palette, [5] priority (1 = behind), [6] horizontal flip.
- load_x  in  X_WIDTH  sprite X coordinate.
- load_isSprite0  in  1  slot holds OAM sprite 0; honoured for slot 0 only.
- spritePixel  out  6  registered pixel {s0, prio, pal[1:0], pat[1:0]}.
- slotActiveMask  out  SLOT_COUNT  debug: bit n set while slot n is shifting.

Behaviour:
- Reset (asynchronous): all slot registers, the dot counter, spritePixel and slotActiveMask go to 0.
- Nothing changes while clock_EN is 0.
- Per-slot state machine:
  - IDLE: load_EN writes the slot, then → WAIT.
  - WAIT: on each render dot, if xCount==0 → SHIFT with shiftCount=7 in that same dot; otherwise decrement xCount.
  - SHIFT: the output bit is the MSB of each plane. Each render dot, shift both planes left and decrement shiftCount. After the 8th pixel → DONE.
  - DONE: holds until the next load_EN. A slot in DONE outputs transparent.
- load_x=0: the slot's pixel 0 appears on the dot with dotX=0.
- Load: if attribute[6] is set, the pattern bits are bit-reversed before storage. xCount=load_x, state=WAIT.
- Load on the same cycle as a render dot for the same slot: the load wins, and that slot contributes transparent on that dot.
- clearSlots and load_EN on the same slot in the same cycle: the load wins. clearSlots also sets every unloaded slot to DONE.
- Dot counter: lineStart sets dotX=0. Otherwise it increments on each render dot and saturates at 2^X_WIDTH-1; no wrap.
- lineStart together with render_EN: this dot uses dotX=0, and the counter becomes 1.
- Arbitration (per render dot):
  - Candidates are slots in SHIFT whose {high MSB, low MSB} != 0.
  - The winner is the lowest-index candidate. Transparent pixels of a higher-priority slot never hide a lower slot.
  - Winner output: {winner==0 && s0flag, attr[5], attr[1:0], pattern}.
  - No winner, or dotX<8 && !showLeft8: output 6'b0.
- Timing: the output is evaluated from the pre-shift state and registered on the same clock_EN edge. Latency is 1 dot from the dot being evaluated.
- Non-render dots with clock_EN: spritePixel ← 0, and slot state is frozen.
- Reset mid-line returns everything to IDLE and transparent output immediately.

Decomposition:
- Shared package ppu_sprite_pkg holds:
  - typedef slot_state_t {IDLE, WAIT, SHIFT, DONE}.
  - Attribute bit-position constants: ATTR_FLIP=6, ATTR_PRIO=5, ATTR_PAL_LO=0.
  - sprite-pixel field constants.
- Sub-module sprite_slot, instanced SLOT_COUNT times by generate. It holds its state machine, counters and shifters, and exposes its current pixel nibble and active flag.
- The top level holds the dot counter, the priority encoder and the output register.

Test Plan:
- Single sprite, slot 3, x=10, patLow=8'hF0, patHigh=8'h00, attr=8'h02, no flip → spritePixel=6'b001001 on dots 10-13 (visible one clock_EN later), 0 on dots 14-17 and beyond.
- Flip: same as above with attr[6]=1 → non-zero output on dots 14-17 instead of 10-13.
- Overlap: slot 0 x=20, pattern 8'h0F; slot 1 x=20, pattern 8'hFF, pal=3 → dots 20-23 come from slot 1 (pal 3); dots 24-27 come from slot 0.
- Sprite-0 flag and priority: slot 0 loaded with isSprite0=1, attr=8'h20 → output bits [5:4]=2'b11 on opaque dots. The same load into slot 2 gives bit 5=0.
- Left clip: x=4, patLow=8'hFF, showLeft8=0 → dots 4-7 output 0, dots 8-11 opaque. With showLeft8=1, dots 4-11 are all opaque.
- Async reset asserted mid-shift between clock edges → spritePixel and slotActiveMask go to 0 at once. After release with no loads, output stays 0.
